// File: rtl/mem_pkg.sv
// Shared types for the memory stage: load/store opcodes, FSM states and
// opcode classification helpers.
package mem_pkg;

    typedef enum logic [3:0] {
        MEM_NONE = 4'd0,
        MEM_LB   = 4'd1,
        MEM_LBU  = 4'd2,
        MEM_LH   = 4'd3,
        MEM_LHU  = 4'd4,
        MEM_LW   = 4'd5,
        MEM_SB   = 4'd6,
        MEM_SH   = 4'd7,
        MEM_SW   = 4'd8
    } mem_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } mem_state_e;

    function automatic logic is_load(input mem_op_e op);
        return (op == MEM_LB) || (op == MEM_LBU) || (op == MEM_LH) ||
               (op == MEM_LHU) || (op == MEM_LW);
    endfunction

    function automatic logic is_store(input mem_op_e op);
        return (op == MEM_SB) || (op == MEM_SH) || (op == MEM_SW);
    endfunction

    // Halfword needs an even address, word needs a multiple of four.
    function automatic logic is_misaligned(input mem_op_e op, input logic [1:0] off);
        case (op)
            MEM_LH, MEM_LHU, MEM_SH: return off[0];
            MEM_LW, MEM_SW:          return (off != 2'b00);
            default:                 return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_if.sv
// Single-outstanding data bus between the memory stage (master) and the
// data memory / bus fabric (slave).
// Handshake: the master raises dbus_req together with dbus_wr/addr/be/wdata
// and holds all of them stable until the cycle in which the slave asserts
// dbus_ack; that cycle completes the access (dbus_rdata is valid with ack for
// loads) and dbus_req drops at the following edge. Ack without req is ignored.
interface mem_if;
    logic        dbus_req;
    logic        dbus_wr;
    logic [31:0] dbus_addr;
    logic [3:0]  dbus_be;
    logic [31:0] dbus_wdata;
    logic [31:0] dbus_rdata;
    logic        dbus_ack;

    modport master (
        output dbus_req, dbus_wr, dbus_addr, dbus_be, dbus_wdata,
        input  dbus_rdata, dbus_ack
    );

    modport slave (
        input  dbus_req, dbus_wr, dbus_addr, dbus_be, dbus_wdata,
        output dbus_rdata, dbus_ack
    );
endinterface

// File: rtl/mem_lane.sv
// Little-endian lane steering: byte enables and store-data replication for
// the outgoing access, byte/half extraction and sign/zero extension for the
// returned load word. Purely combinational.
module mem_lane
    import mem_pkg::*;
(
    input  mem_op_e     i_op,
    input  logic [1:0]  i_off,
    input  logic [31:0] i_store_data,
    input  logic [31:0] i_rdata,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic [31:0] o_load_data
);
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Pick the addressed byte lane and halfword lane out of the read word.
    always_comb begin
        w_byte = i_rdata[7:0];
        case (i_off)
            2'd1:    w_byte = i_rdata[15:8];
            2'd2:    w_byte = i_rdata[23:16];
            2'd3:    w_byte = i_rdata[31:24];
            default: w_byte = i_rdata[7:0];
        endcase
        w_half = i_off[1] ? i_rdata[31:16] : i_rdata[15:0];
    end

    // Size-dependent enables, replication and extension; low bits below the
    // access size are ignored, which aligns misaligned accesses down.
    always_comb begin
        o_be        = 4'b0000;
        o_wdata     = i_store_data;
        o_load_data = i_rdata;
        case (i_op)
            MEM_LB: begin
                o_be        = 4'b0001 << i_off;
                o_load_data = {{24{w_byte[7]}}, w_byte};
            end
            MEM_LBU: begin
                o_be        = 4'b0001 << i_off;
                o_load_data = {24'd0, w_byte};
            end
            MEM_LH: begin
                o_be        = i_off[1] ? 4'b1100 : 4'b0011;
                o_load_data = {{16{w_half[15]}}, w_half};
            end
            MEM_LHU: begin
                o_be        = i_off[1] ? 4'b1100 : 4'b0011;
                o_load_data = {16'd0, w_half};
            end
            MEM_LW: begin
                o_be = 4'b1111;
            end
            MEM_SB: begin
                o_be    = 4'b0001 << i_off;
                o_wdata = {4{i_store_data[7:0]}};
            end
            MEM_SH: begin
                o_be    = i_off[1] ? 4'b1100 : 4'b0011;
                o_wdata = {2{i_store_data[15:0]}};
            end
            MEM_SW: begin
                o_be = 4'b1111;
            end
            default: begin
                o_be = 4'b0000;
            end
        endcase
    end
endmodule

// File: rtl/mem_stage.sv
// MIPS-style memory stage. Non-memory ops pass straight through to the mem_*
// registers (which also feed forwarding back to EX). Loads and stores issue
// one access on the data bus and hold the pipeline via stall_req until ack or
// until ACK_TIMEOUT BUSY cycles elapse (bus_err pulse, instruction dropped).
// Optional build macro: MEM_ALIGN_CHECK_EN -- misaligned half/word accesses
// are rejected with an addr_err pulse instead of being aligned down.
module mem_stage
    import mem_pkg::*;
#(
    parameter int ACK_TIMEOUT = 16,
    parameter int TO_W        = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ex_we,
    input  logic [4:0]  ex_waddr,
    input  logic [31:0] ex_wdata,
    input  logic        ex_whilo,
    input  logic [31:0] ex_hi,
    input  logic [31:0] ex_lo,
    input  logic [3:0]  ex_mem_op,
    input  logic [31:0] ex_mem_addr,
    input  logic [31:0] ex_store_data,
    output logic        mem_we,
    output logic [4:0]  mem_waddr,
    output logic [31:0] mem_wdata,
    output logic        mem_whilo,
    output logic [31:0] mem_hi,
    output logic [31:0] mem_lo,
    output logic        stall_req,
    output logic        bus_err,
`ifdef MEM_ALIGN_CHECK_EN
    output logic        addr_err,
`endif
    output mem_state_e  o_dbg_state,
    mem_if.master       dbus
);
    mem_state_e    r_state;
    logic [TO_W-1:0] r_cnt;
    mem_op_e       r_op;
    logic [1:0]    r_off;
    logic          r_we;
    logic [4:0]    r_waddr;
    logic          r_mem_we, r_mem_whilo, r_bus_err;
    logic [4:0]    r_mem_waddr;
    logic [31:0]   r_mem_wdata, r_mem_hi, r_mem_lo;
    logic          r_req, r_wr;
    logic [31:0]   r_addr, r_wdata;
    logic [3:0]    r_be;
`ifdef MEM_ALIGN_CHECK_EN
    logic          r_addr_err;
`endif

    mem_op_e       w_ex_op, w_lane_op;
    logic [1:0]    w_lane_off;
    logic          w_is_mem, w_misalign, w_timeout;
    logic [3:0]    w_be;
    logic [31:0]   w_wdata, w_load_data;

    assign w_ex_op   = mem_op_e'(ex_mem_op);
    assign w_is_mem  = is_load(w_ex_op) || is_store(w_ex_op);
    assign w_timeout = (r_state == ST_BUSY) && !dbus.dbus_ack &&
                       (r_cnt == TO_W'(ACK_TIMEOUT - 1));
`ifdef MEM_ALIGN_CHECK_EN
    assign w_misalign = w_is_mem && is_misaligned(w_ex_op, ex_mem_addr[1:0]);
`else
    assign w_misalign = 1'b0;
`endif

    // One lane steerer: fed from EX while issuing, from the latched access
    // while waiting for the load data.
    assign w_lane_op  = (r_state == ST_BUSY) ? r_op : w_ex_op;
    assign w_lane_off = (r_state == ST_BUSY) ? r_off : ex_mem_addr[1:0];

    mem_lane u_lane (
        .i_op         (w_lane_op),
        .i_off        (w_lane_off),
        .i_store_data (ex_store_data),
        .i_rdata      (dbus.dbus_rdata),
        .o_be         (w_be),
        .o_wdata      (w_wdata),
        .o_load_data  (w_load_data)
    );

    // Freeze upstream while an access is being issued or is still unacked;
    // the ack cycle and the timeout cycle release it.
    always_comb begin
        stall_req = 1'b0;
        if (r_state == ST_IDLE) begin
            stall_req = w_is_mem && !w_misalign;
        end else begin
            stall_req = !dbus.dbus_ack && !w_timeout;
        end
    end

    // Pipeline register plus bus FSM: pass-through, issue, ack or timeout.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_op        <= MEM_NONE;
            r_off       <= 2'b00;
            r_we        <= 1'b0;
            r_waddr     <= 5'd0;
            r_mem_we    <= 1'b0;
            r_mem_waddr <= 5'd0;
            r_mem_wdata <= 32'd0;
            r_mem_whilo <= 1'b0;
            r_mem_hi    <= 32'd0;
            r_mem_lo    <= 32'd0;
            r_bus_err   <= 1'b0;
            r_req       <= 1'b0;
            r_wr        <= 1'b0;
            r_addr      <= 32'd0;
            r_be        <= 4'd0;
            r_wdata     <= 32'd0;
`ifdef MEM_ALIGN_CHECK_EN
            r_addr_err  <= 1'b0;
`endif
        end else begin
            r_bus_err <= 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
            r_addr_err <= 1'b0;
`endif
            case (r_state)
                ST_IDLE: begin
                    if (w_is_mem) begin
                        // Memory ops leave a bubble until their result is ready.
                        r_mem_we    <= 1'b0;
                        r_mem_whilo <= 1'b0;
                        if (w_misalign) begin
`ifdef MEM_ALIGN_CHECK_EN
                            r_addr_err <= 1'b1;
`endif
                        end else begin
                            r_state <= ST_BUSY;
                            r_cnt   <= '0;
                            r_op    <= w_ex_op;
                            r_off   <= ex_mem_addr[1:0];
                            r_we    <= ex_we;
                            r_waddr <= ex_waddr;
                            r_req   <= 1'b1;
                            r_wr    <= is_store(w_ex_op);
                            r_addr  <= {ex_mem_addr[31:2], 2'b00};
                            r_be    <= w_be;
                            r_wdata <= w_wdata;
                        end
                    end else begin
                        r_mem_we    <= ex_we;
                        r_mem_waddr <= ex_waddr;
                        r_mem_wdata <= ex_wdata;
                        r_mem_whilo <= ex_whilo;
                        r_mem_hi    <= ex_hi;
                        r_mem_lo    <= ex_lo;
                    end
                end
                ST_BUSY: begin
                    if (dbus.dbus_ack) begin
                        r_state <= ST_IDLE;
                        r_req   <= 1'b0;
                        if (is_load(r_op)) begin
                            r_mem_we    <= r_we;
                            r_mem_waddr <= r_waddr;
                            r_mem_wdata <= w_load_data;
                        end else begin
                            r_mem_we <= 1'b0;
                        end
                    end else if (w_timeout) begin
                        r_state   <= ST_IDLE;
                        r_req     <= 1'b0;
                        r_bus_err <= 1'b1;
                        r_mem_we  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + TO_W'(1);
                    end
                end
            endcase
        end
    end

    assign mem_we          = r_mem_we;
    assign mem_waddr       = r_mem_waddr;
    assign mem_wdata       = r_mem_wdata;
    assign mem_whilo       = r_mem_whilo;
    assign mem_hi          = r_mem_hi;
    assign mem_lo          = r_mem_lo;
    assign bus_err         = r_bus_err;
    assign o_dbg_state     = r_state;
    assign dbus.dbus_req   = r_req;
    assign dbus.dbus_wr    = r_wr;
    assign dbus.dbus_addr  = r_addr;
    assign dbus.dbus_be    = r_be;
    assign dbus.dbus_wdata = r_wdata;
`ifdef MEM_ALIGN_CHECK_EN
    assign addr_err        = r_addr_err;
`endif
endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
MIPS-style memory pipeline stage, directly downstream of the execute stage. Consumes EX results (GPR write, HI/LO write, load/store request), performs byte/half/word accesses on a single-outstanding data bus, and registers results toward writeback. Registered outputs double as the mem_* forwarding path back to EX. Asserts stall_req while a bus access is pending.

Parameters:
ACK_TIMEOUT, 16, max cycles in BUSY waiting for dbus_ack before abort (>=2)
TO_W, 5, width of timeout counter (must hold ACK_TIMEOUT)

Ports:
clk  in  1  pipeline clock
reset  in  1  synchronous, active-high reset
ex_we  in  1  GPR write enable from EX
ex_waddr  in  5  GPR destination
ex_wdata  in  32  ALU result / pass-through data
ex_whilo  in  1  HI/LO write enable
ex_hi  in  32  HI value
ex_lo  in  32  LO value
ex_mem_op  in  4  load/store opcode (package enum; MEM_NONE = no access)
ex_mem_addr  in  32  effective byte address
ex_store_data  in  32  store source (rt)
mem_we  out  1  GPR write enable to WB / forward
mem_waddr  out  5  GPR destination
mem_wdata  out  32  final write data (load-extended or pass-through)
mem_whilo  out  1  HI/LO write enable
mem_hi  out  32  HI value
mem_lo  out  32  LO value
stall_req  out  1  freeze request to pipeline control (combinational)
bus_err  out  1  one-cycle pulse on access timeout
dbus_req  out  1  bus request, held until ack
dbus_wr  out  1  1=store, 0=load
dbus_addr  out  32  word-aligned address ({addr[31:2],2'b00})
dbus_be  out  4  byte enables, lane0 = bits 7:0
dbus_wdata  out  32  lane-replicated store data
dbus_rdata  in  32  load data, valid with ack
dbus_ack  in  1  access complete

Behaviour:
- One clock; reset is synchronous and active-high. On reset: all outputs 0, state IDLE, counter 0; aborts any in-flight access (dbus_req drops at that edge).
- Non-memory op (MEM_NONE): ex_* copied to mem_* at next edge; 1-cycle latency; stall_req=0.
- FSM IDLE/BUSY. IDLE with memory op: stall_req=1; latch addr/be/wdata/op/waddr/we; ->BUSY with dbus_req=1 registered; mem_we/mem_whilo written 0 (bubble).
- BUSY: dbus_req, dbus_addr, dbus_be, dbus_wdata, dbus_wr stable. stall_req = !dbus_ack. On ack: ->IDLE, dbus_req=0 at edge; register result: loads mem_we=latched we, mem_wdata=extracted data; stores mem_we=0. Upstream holds ex_* stable while stall_req=1; ex_* in ack cycle belong to same instruction (not re-issued).
- Little-endian lanes: byte lane = addr[1:0]; half lane = addr[1]. LB/LH sign-extend, LBU/LHU zero-extend, LW full word. SB be=1<<addr[1:0], wdata={4{byte}}; SH be=addr[1]?1100:0011, wdata={2{half}}; SW be=1111.
- Misaligned half/word: addr low bits ignored per lane rule (aligned down) unless feature enabled.
- Timeout: counter counts BUSY cycles; reaching ACK_TIMEOUT without ack -> bus_err pulse, ->IDLE, dbus_req=0, mem_we=0, stall_req=0 that cycle.
- Ack in IDLE ignored. HI/LO fields pass through only on non-memory ops.

Optional Feature:
MEM_ALIGN_CHECK_EN: defined -> half with addr[0]=1 or word with addr[1:0]!=0 issues no bus request, stays IDLE, outputs bubble (mem_we=0), drives extra output addr_err (1-cycle pulse, 0 on reset). Undefined -> no addr_err port, addresses aligned down.

Decomposition:
- Package mem_pkg: mem_op enum (NONE=0,LB=1,LBU=2,LH=3,LHU=4,LW=5,SB=6,SH=7,SW=8), state enum, is_load/is_store helpers.
- Sub-module mem_lane: combinational lane steering (be, store replication, load extract/extend); instantiated once.

Test Plan:
- Pass-through: ex_we=1,waddr=5,wdata=0x1234 MEM_NONE -> next cycle mem_we=1,mem_waddr=5,mem_wdata=0x1234, stall_req=0.
- LB addr=0x103, ack 2 cycles after req, rdata=0x80FF_FF00 -> be=1000, stall 3 cycles, mem_wdata=0xFFFF_FF80; LBU -> 0x0000_0080.
- SH addr=0x22 data=0xAAAA_BEEF -> dbus_addr=0x20, be=1100, wdata=0xBEEF_BEEF, dbus_wr=1, mem_we=0.
- Same-cycle ack: LW ack first BUSY cycle, rdata=0xDEAD_BEEF -> stall_req exactly 1 cycle, mem_wdata=0xDEAD_BEEF.
- No ack, ACK_TIMEOUT=16 -> bus_err pulse after 16 BUSY cycles, dbus_req=0, stall released.
- Reset asserted in BUSY -> next edge dbus_req=0, all outputs 0, IDLE; with MEM_ALIGN_CHECK_EN, LW addr=0x2 -> addr_err=1, no dbus_req.
